// File: rtl/fdiv_issue_ctrl.sv
// Issue/result sequencer around the combinational fdiv_core: holds operands for LAT cycles,
// captures the quotient and flags, and keeps sticky fflags. Optional: FDIV_ISSUE_EARLY_OUT_EN.
module fdiv_issue_ctrl #(
    parameter int NEXP = 8,
    parameter int NSIG = 23,
    parameter int LAT  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NEXP+NSIG:0]   in_a,
    input  logic [NEXP+NSIG:0]   in_b,
    input  logic                 in_rm,
    output logic [NEXP+NSIG:0]   core_a,
    output logic [NEXP+NSIG:0]   core_b,
    output logic                 core_rm,
    input  logic [NEXP+NSIG:0]   core_y,
    input  logic [4:0]           core_flags,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NEXP+NSIG:0]   out_y,
    output logic [4:0]           out_flags,
    output logic [4:0]           fflags,
    input  logic                 fflags_we,
    input  logic [4:0]           fflags_wdata
);

    localparam int W = NEXP + NSIG + 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] cnt;
    logic [3:0] load_cnt;
    logic       accept;
    logic       capture;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign capture   = (state == WAIT) && (cnt == 4'd1);

`ifdef FDIV_ISSUE_EARLY_OUT_EN
    // Inf/NaN or signed zero: the core's answer needs no real division, so sample it next cycle.
    function automatic logic is_special(input logic [W-1:0] x);
        logic [NEXP-1:0] e;
        logic [NSIG-1:0] f;
        e = x[W-2 -: NEXP];
        f = x[NSIG-1:0];
        return (&e) || ((e == '0) && (f == '0));
    endfunction

    assign load_cnt = (is_special(in_a) || is_special(in_b)) ? 4'd1 : 4'(LAT);
`else
    assign load_cnt = 4'(LAT);
`endif

    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        // NOTE: default first so no path leaves state_next unassigned (avoids a latch).
        state_next = state;
        case (state)
            IDLE:    if (accept)    state_next = WAIT;
            WAIT:    if (capture)   state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            core_a    <= '0;
            core_b    <= '0;
            core_rm   <= 1'b0;
            out_y     <= '0;
            out_flags <= '0;
            fflags    <= '0;
        end else begin
            if (accept) begin
                core_a  <= in_a;
                core_b  <= in_b;
                core_rm <= in_rm;
                cnt     <= load_cnt;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end

            if (capture) begin
                out_y     <= core_y;
                out_flags <= core_flags;
            end

            // A CSR write landing on a capture cycle keeps the captured flags as well.
            fflags <= (fflags_we ? fflags_wdata : fflags) | (capture ? core_flags : 5'd0);
        end
    end

endmodule

// File: tb/tb_fdiv_issue_ctrl.sv
// Directed bench for fdiv_issue_ctrl; a table-driven stub stands in for fdiv_core.
module tb_fdiv_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_rm;
    logic [31:0] core_a;
    logic [31:0] core_b;
    logic        core_rm;
    logic [31:0] core_y;
    logic [4:0]  core_flags;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_y;
    logic [4:0]  out_flags;
    logic [4:0]  fflags;
    logic        fflags_we;
    logic [4:0]  fflags_wdata;

    int n_checks = 0;
    int n_errors = 0;

`ifdef FDIV_ISSUE_EARLY_OUT_EN
    localparam int DIV0_LAT = 1;
`else
    localparam int DIV0_LAT = 4;
`endif

    always #5 clk = ~clk;

    fdiv_issue_ctrl #(.NEXP(8), .NSIG(23), .LAT(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_rm        (in_rm),
        .core_a       (core_a),
        .core_b       (core_b),
        .core_rm      (core_rm),
        .core_y       (core_y),
        .core_flags   (core_flags),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_y        (out_y),
        .out_flags    (out_flags),
        .fflags       (fflags),
        .fflags_we    (fflags_we),
        .fflags_wdata (fflags_wdata)
    );

    // Known quotients for the operand pairs used below.
    always_comb begin
        core_y     = 32'h7FC00000;
        core_flags = 5'b10000;
        case ({core_a, core_b})
            {32'h3F800000, 32'h40000000}: begin core_y = 32'h3F000000; core_flags = 5'b00000; end
            {32'h3F800000, 32'h40400000}: begin
                core_y     = core_rm ? 32'h3EAAAAAB : 32'h3EAAAAAA;
                core_flags = 5'b00001;
            end
            {32'h40800000, 32'h40000000}: begin core_y = 32'h40000000; core_flags = 5'b00000; end
            {32'h3F800000, 32'h00000000}: begin core_y = 32'h7F800000; core_flags = 5'b01000; end
            {32'h40400000, 32'h3F800000}: begin core_y = 32'h40400000; core_flags = 5'b00000; end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic accept_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input logic rm);
        wait_ready(tag);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_rm    = rm;
        step();
        in_valid = 1'b0;
        check({tag, " core_a"}, core_a, a);
        check({tag, " core_b"}, core_b, b);
    endtask

    task automatic wait_result(input string tag, input int exp_lat);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!out_valid && n < 20);
        check({tag, " latency"}, 32'(n), 32'(exp_lat));
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic rm, input int exp_lat, input logic [31:0] exp_y,
                          input logic [4:0] exp_fl, input logic [4:0] exp_ff);
        accept_op(tag, a, b, rm);
        check({tag, " core_rm"}, 32'(core_rm), 32'(rm));
        wait_result(tag, exp_lat);
        check({tag, " out_y"}, out_y, exp_y);
        check({tag, " out_flags"}, 32'(out_flags), 32'(exp_fl));
        check({tag, " fflags"}, 32'(fflags), 32'(exp_ff));
    endtask

    initial begin
        logic seen_valid;

        reset        = 1'b1;
        in_valid     = 1'b0;
        in_a         = '0;
        in_b         = '0;
        in_rm        = 1'b0;
        out_ready    = 1'b1;
        fflags_we    = 1'b0;
        fflags_wdata = '0;
        step();
        step();
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst core_a", core_a, 32'd0);
        check("rst out_y", out_y, 32'd0);
        check("rst fflags", 32'(fflags), 32'd0);
        reset = 1'b0;
        step();
        check("post-rst in_ready", 32'(in_ready), 32'd1);

        // Plain divide, inexact with sticky accumulation, then divide by zero.
        run_op("1/2", 32'h3F800000, 32'h40000000, 1'b1, 4, 32'h3F000000, 5'b00000, 5'b00000);
        run_op("1/3", 32'h3F800000, 32'h40400000, 1'b1, 4, 32'h3EAAAAAB, 5'b00001, 5'b00001);
        run_op("4/2", 32'h40800000, 32'h40000000, 1'b1, 4, 32'h40000000, 5'b00000, 5'b00001);
        run_op("1/0", 32'h3F800000, 32'h00000000, 1'b0, DIV0_LAT, 32'h7F800000, 5'b01000,
               5'b01001);
        step();
        check("1/0 handshake out_valid", 32'(out_valid), 32'd0);
        check("1/0 handshake in_ready", 32'(in_ready), 32'd1);

        // Backpressure: result held for 10 cycles with out_ready low.
        out_ready = 1'b0;
        run_op("bp", 32'h3F800000, 32'h40000000, 1'b1, 4, 32'h3F000000, 5'b00000, 5'b01001);
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("bp hold%0d out_y", i), out_y, 32'h3F000000);
            check($sformatf("bp hold%0d out_flags", i), 32'(out_flags), 32'd0);
            check($sformatf("bp hold%0d in_ready", i), 32'(in_ready), 32'd0);
            check($sformatf("bp hold%0d out_valid", i), 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        step();
        check("bp release out_valid", 32'(out_valid), 32'd0);
        check("bp release in_ready", 32'(in_ready), 32'd1);

        // CSR write on the capture edge of an inexact op.
        accept_op("csr", 32'h3F800000, 32'h40400000, 1'b1);
        step();
        step();
        step();
        check("csr pre-capture out_valid", 32'(out_valid), 32'd0);
        fflags_we    = 1'b1;
        fflags_wdata = 5'b10000;
        step();
        fflags_we = 1'b0;
        check("csr capture out_valid", 32'(out_valid), 32'd1);
        check("csr collision fflags", 32'(fflags), 32'h11);
        step();
        fflags_we    = 1'b1;
        fflags_wdata = 5'b00000;
        step();
        fflags_we = 1'b0;
        check("csr clear fflags", 32'(fflags), 32'd0);

        // Reset mid-WAIT with cnt == 2.
        fflags_we    = 1'b1;
        fflags_wdata = 5'b00110;
        step();
        fflags_we = 1'b0;
        check("pre-rst fflags", 32'(fflags), 32'h06);
        accept_op("midrst", 32'h3F800000, 32'h40000000, 1'b1);
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst out_valid", 32'(out_valid), 32'd0);
        check("midrst in_ready", 32'(in_ready), 32'd1);
        check("midrst out_y", out_y, 32'd0);
        check("midrst out_flags", 32'(out_flags), 32'd0);
        check("midrst fflags", 32'(fflags), 32'd0);
        check("midrst core_a", core_a, 32'd0);
        seen_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            seen_valid = seen_valid | out_valid;
        end
        check("midrst no result", 32'(seen_valid), 32'd0);
        run_op("3/1", 32'h40400000, 32'h3F800000, 1'b1, 4, 32'h40400000, 5'b00000, 5'b00000);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fdiv_issue_ctrl.md
# fdiv_issue_ctrl

- Sequencing and result stage wrapped around the combinational single-precision divider `fdiv_core`.
- Accepts operand pairs over a valid/ready handshake and holds them registered and stable on the core's inputs for `LAT` cycles, so the divider is a multicycle path.
- Captures the core's result and exception flags, presents them over a valid/ready handshake, and accumulates flags into a sticky `fflags` register read by the CSR logic.

## Interface
- `NEXP`, 8, exponent width (matches core)
- `NSIG`, 23, stored fraction width (matches core)
- `LAT`, 4, cycles the core operands are held before the result is sampled; legal 1..15
- `clk`  in  1  clock; one clock domain
- `reset`  in  1  synchronous, active-high reset
- `in_valid`  in  1  operand pair valid
- `in_ready`  out  1  block can accept operands
- `in_a`, `in_b`  in  NEXP+NSIG+1  dividend, divisor
- `in_rm`  in  1  rounding mode (0 = truncate, 1 = nearest-even)
- `core_a`, `core_b`  out  NEXP+NSIG+1  registered operands to `fdiv_core`
- `core_rm`  out  1  registered rounding mode to the core
- `core_y`  in  NEXP+NSIG+1  core quotient
- `core_flags`  in  5  core flags {invalid, div0, ovf, udf, inx}
- `out_valid`  out  1  result valid
- `out_ready`  in  1  consumer accepts result
- `out_y`  out  NEXP+NSIG+1  registered quotient
- `out_flags`  out  5  registered flags for this operation
- `fflags`  out  5  sticky accumulated flags
- `fflags_we`  in  1  CSR write strobe
- `fflags_wdata`  in  5  CSR write data

## Operation
- FSM states: IDLE, WAIT, DONE.
- `in_ready` = (state == IDLE).
- **IDLE:** on `in_valid & in_ready`:
  - load `core_a`/`core_b`/`core_rm` from the inputs;
  - load counter `cnt` = `LAT`;
  - go to WAIT.
- **WAIT:**
  - `cnt` decrements each cycle.
  - On the cycle where `cnt == 1`: load `out_y` ← `core_y`, `out_flags` ← `core_flags`, accumulate flags, go to DONE.
- **DONE:**
  - `out_valid` = 1.
  - `out_y` and `out_flags` are held stable until `out_ready`.
  - On `out_valid & out_ready`, go to IDLE.
- Core operand registers change only on input acceptance; they hold their value in WAIT, DONE and IDLE.
- Flag accumulation: `fflags_next` = (`fflags_we` ? `fflags_wdata` : `fflags`) | (capture ? `core_flags` : 0).
  - When a CSR write and a capture land on the same cycle, the OR of both wins.
- `cnt` width is 4 bits.
- Reset values (any state, including mid-WAIT; any in-flight operation is discarded):
  - state IDLE
  - `cnt` 0
  - `core_a`, `core_b`, `core_rm` all 0
  - `out_y`, `out_flags` 0
  - `out_valid` 0
  - `fflags` 0
- `in_ready` is 1 in the cycle after reset deasserts.

## Timing
- Acceptance at edge k: `core_a`/`core_b` valid from k+1.
- Result sampled at edge k+`LAT`; `out_valid` is high from k+`LAT`.
- Accept-to-result latency = `LAT` cycles.
- No new acceptance while in WAIT or DONE.
  - Minimum issue interval is `LAT`+1 cycles with `out_ready` tied high.
- `out_valid` drops the cycle after the handshake.
- `in_ready` rises in that same cycle.

## Configuration
- Macro: `FDIV_ISSUE_EARLY_OUT_EN`.
- **Defined:**
  - At acceptance, `in_a`/`in_b` are classified: exponent all-ones (Inf/NaN), or exponent and fraction all-zero (±0).
  - If either operand is special, `cnt` loads 1, so the result is captured at k+1 and latency is 1.
  - Normal and subnormal operands still take `LAT` cycles.
- **Undefined:** every operation takes `LAT` cycles and no classification logic is present.

## Test plan
- **Basic divide:** `LAT`=4, `in_a`=0x3F800000, `in_b`=0x40000000, `in_rm`=1, `out_ready`=1 → `out_valid` rises 4 cycles after acceptance; `out_y`=0x3F000000, `out_flags`=0, `fflags`=0.
- **Inexact + sticky accumulation:** 0x3F800000 / 0x40400000, `in_rm`=1 → `out_y`=0x3EAAAAAB, `out_flags`=5'b00001. Then 4.0/2.0 → `out_flags`=0 and `fflags` stays 5'b00001.
- **Divide by zero:** 0x3F800000 / 0x00000000 → `out_y`=0x7F800000, `out_flags`=5'b01000.
  - Latency is 1 with `FDIV_ISSUE_EARLY_OUT_EN` defined, 4 without.
- **Backpressure:** hold `out_ready`=0 for 10 cycles after `out_valid` → `out_y`/`out_flags` stable and `in_ready`=0 throughout. Then assert `out_ready` → next-cycle `in_ready`=1 and `out_valid`=0.
- **CSR write vs capture collision:** `fflags_we`=1 with `fflags_wdata`=5'b10000 on the capture cycle of an inexact op → `fflags`=5'b10001. Then `fflags_we` with data 0 on an idle cycle → `fflags`=0.
- **Reset mid-operation:** assert `reset` in WAIT with `cnt`=2 → next cycle state IDLE, `out_valid`=0, `out_y`/`out_flags`/`fflags` = 0, and no result is ever emitted. A new op after reset completes normally.
